// File: rtl/bf16_add_rr_sched_pkg.sv
// Shared bf16 definitions for the round-robin adder scheduler.
package bf16_add_rr_sched_pkg;
   localparam int BF16_W = 16;
   typedef logic [BF16_W-1:0] bf16_t;

   localparam bf16_t BF16_ONE  = 16'h3F80;
   localparam bf16_t BF16_TWO  = 16'h4000;
   localparam bf16_t BF16_PINF = 16'h7F80;
   localparam bf16_t BF16_QNAN = 16'h7FC0;

   function automatic logic bf16_is_nan(input bf16_t x);
      return (x[14:7] == 8'hFF) && (x[6:0] != 7'd0);
   endfunction
endpackage

// File: rtl/bf16_add_rr_sched_arb.sv
// Round-robin arbiter: first requester at or after ptr wins, scanning modulo N.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] winner,
   output logic                 any
);
   int idx_s;

   // Priority scan starting at ptr with wrap-around.
   always_comb begin
      grant  = '0;
      winner = '0;
      any    = 1'b0;
      idx_s  = 0;
      for (int k = 0; k < N; k++) begin
         idx_s = int'(ptr) + k;
         if (idx_s >= N) begin
            idx_s = idx_s - N;
         end else begin
            idx_s = idx_s;
         end
         if (!any && req[idx_s]) begin
            any           = 1'b1;
            grant[idx_s]  = 1'b1;
            winner        = ($clog2(N))'(idx_s);
         end else begin
            any = any;
         end
      end
   end
endmodule

// File: rtl/bf16_adder1.sv
// Combinational bf16 adder, round-to-nearest-even, subnormal inputs/outputs flushed to zero.
module bf16_adder1
   import bf16_add_rr_sched_pkg::*;
(
   input  bf16_t a,
   input  bf16_t b,
   input  logic  a_vld,
   input  logic  b_vld,
   output bf16_t z,
   output logic  z_vld
);
   logic        sl_s, ss_s, found_s, stk_s, rup_s;
   logic [7:0]  el_s, es_s, d_s;
   logic [6:0]  ml_s, ms_s;
   logic [15:0] fl_s, fs_s, sh_s, nrm_s;
   logic [16:0] sum_s;
   logic [9:0]  e_s;
   logic [4:0]  lz_s;
   logic [8:0]  rnd_s;
   bf16_t       core_s;

   assign z_vld = a_vld & b_vld;

   // Align the smaller operand (sticky-jammed), add/subtract, normalise, round, then pick specials.
   always_comb begin
      if (a[14:0] >= b[14:0]) begin
         sl_s = a[15]; el_s = a[14:7]; ml_s = a[6:0];
         ss_s = b[15]; es_s = b[14:7]; ms_s = b[6:0];
      end else begin
         sl_s = b[15]; el_s = b[14:7]; ml_s = b[6:0];
         ss_s = a[15]; es_s = a[14:7]; ms_s = a[6:0];
      end
      d_s  = el_s - es_s;
      fl_s = {1'b1, ml_s, 8'h00};
      fs_s = {1'b1, ms_s, 8'h00};
      if (d_s >= 8'd16) begin
         sh_s  = 16'h0000;
         stk_s = 1'b1;
      end else begin
         sh_s  = fs_s >> d_s;
         stk_s = |(fs_s & ~(16'hFFFF << d_s));
      end
      sh_s[0] = sh_s[0] | stk_s;
      if (sl_s == ss_s) begin
         sum_s = {1'b0, fl_s} + {1'b0, sh_s};
      end else begin
         sum_s = {1'b0, fl_s} - {1'b0, sh_s};
      end
      e_s     = {2'b00, el_s};
      lz_s    = 5'd0;
      found_s = 1'b0;
      if (sum_s[16]) begin
         nrm_s    = sum_s[16:1];
         nrm_s[0] = sum_s[1] | sum_s[0];
         e_s      = e_s + 10'd1;
      end else begin
         for (int i = 15; i >= 0; i--) begin
            if (!found_s && sum_s[i]) begin
               lz_s    = 5'(15 - i);
               found_s = 1'b1;
            end
         end
         nrm_s = sum_s[15:0] << lz_s;
         e_s   = e_s - {5'd0, lz_s};
      end
      rup_s = nrm_s[7] & ((|nrm_s[6:0]) | nrm_s[8]);
      rnd_s = {1'b0, nrm_s[15:8]} + {8'd0, rup_s};
      if (rnd_s[8]) begin
         rnd_s = {1'b0, rnd_s[8:1]};
         e_s   = e_s + 10'd1;
      end else begin
         rnd_s = rnd_s;
      end
      if (sum_s == 17'd0) begin
         core_s = 16'h0000;
      end else if (e_s[9] || (e_s == 10'd0) || !rnd_s[7]) begin
         core_s = {sl_s, 15'd0};
      end else if (e_s >= 10'd255) begin
         core_s = {sl_s, BF16_PINF[14:0]};
      end else begin
         core_s = {sl_s, e_s[7:0], rnd_s[6:0]};
      end

      if (bf16_is_nan(a) || bf16_is_nan(b)) begin
         z = BF16_QNAN;
      end else if ((a[14:7] == 8'hFF) && (b[14:7] == 8'hFF) && (a[15] != b[15])) begin
         z = BF16_QNAN;
      end else if (a[14:7] == 8'hFF) begin
         z = a;
      end else if (b[14:7] == 8'hFF) begin
         z = b;
      end else if ((a[14:7] == 8'h00) && (b[14:7] == 8'h00)) begin
         z = {a[15] & b[15], 15'd0};
      end else if (a[14:7] == 8'h00) begin
         z = b;
      end else if (b[14:7] == 8'h00) begin
         z = a;
      end else begin
         z = core_s;
      end
   end
endmodule

// File: rtl/bf16_add_rr_sched.sv
// Shares one bf16 adder among NREQ requesters through a two-stage valid/ready pipeline.
module bf16_add_rr_sched
   import bf16_add_rr_sched_pkg::*;
#(
   parameter int          NREQ       = 4,
   parameter int          TAGW       = 4,
   parameter logic [31:0] OP_CNT_RST = 32'h0000_0000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ*16-1:0]       req_a,
   input  logic [NREQ*16-1:0]       req_b,
   input  logic [NREQ*TAGW-1:0]     req_tag,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [15:0]              res_z,
   output logic [$clog2(NREQ)-1:0]  res_id,
   output logic [TAGW-1:0]          res_tag,
   output logic                     busy,
   output logic [31:0]              op_cnt
);
   localparam int IDW = $clog2(NREQ);

   logic [NREQ-1:0] grant_s;
   logic [IDW-1:0]  winner_s;
   logic            any_s, s1_en_s, s2_en_s, xfer_s, add_vld_s;
   bf16_t           add_z_s;

   logic            s1_vld_q, s1_vld_d, res_valid_q, res_valid_d;
   bf16_t           s1_a_q, s1_a_d, s1_b_q, s1_b_d, res_z_q, res_z_d;
   logic [IDW-1:0]  s1_id_q, s1_id_d, res_id_q, res_id_d, ptr_q, ptr_d;
   logic [TAGW-1:0] s1_tag_q, s1_tag_d, res_tag_q, res_tag_d;
   logic [31:0]     op_cnt_q, op_cnt_d;

   rr_arbiter #(.N(NREQ)) u_arb (
      .req    (req_valid),
      .ptr    (ptr_q),
      .grant  (grant_s),
      .winner (winner_s),
      .any    (any_s)
   );

   bf16_adder1 u_add (
      .a     (s1_a_q),
      .b     (s1_b_q),
      .a_vld (1'b1),
      .b_vld (1'b1),
      .z     (add_z_s),
      .z_vld (add_vld_s)
   );

   // Stage enables, grant qualification and next-state for both stages, pointer and counter.
   always_comb begin
      s2_en_s   = !res_valid_q | res_ready;
      s1_en_s   = !s1_vld_q | s2_en_s;
      req_ready = grant_s & {NREQ{s1_en_s}};
      xfer_s    = any_s & s1_en_s;

      s1_vld_d = s1_vld_q;
      s1_a_d   = s1_a_q;
      s1_b_d   = s1_b_q;
      s1_id_d  = s1_id_q;
      s1_tag_d = s1_tag_q;
      if (s1_en_s) begin
         s1_vld_d = any_s;
         s1_a_d   = req_a[16*winner_s +: 16];
         s1_b_d   = req_b[16*winner_s +: 16];
         s1_id_d  = winner_s;
         s1_tag_d = req_tag[TAGW*winner_s +: TAGW];
      end else begin
         s1_vld_d = s1_vld_q;
      end

      res_valid_d = res_valid_q;
      res_z_d     = res_z_q;
      res_id_d    = res_id_q;
      res_tag_d   = res_tag_q;
      if (s2_en_s) begin
         res_valid_d = s1_vld_q & add_vld_s;
         res_z_d     = add_z_s;
         res_id_d    = s1_id_q;
         res_tag_d   = s1_tag_q;
      end else begin
         res_valid_d = res_valid_q;
      end

      if (xfer_s) begin
         ptr_d    = (winner_s == IDW'(NREQ - 1)) ? '0 : winner_s + IDW'(1);
         op_cnt_d = op_cnt_q + 32'd1;
      end else begin
         ptr_d    = ptr_q;
         op_cnt_d = op_cnt_q;
      end
   end

   // Pipeline, pointer and counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld_q    <= 1'b0;
         s1_a_q      <= 16'h0000;
         s1_b_q      <= 16'h0000;
         s1_id_q     <= '0;
         s1_tag_q    <= '0;
         res_valid_q <= 1'b0;
         res_z_q     <= 16'h0000;
         res_id_q    <= '0;
         res_tag_q   <= '0;
         ptr_q       <= '0;
         op_cnt_q    <= OP_CNT_RST;
      end else begin
         s1_vld_q    <= s1_vld_d;
         s1_a_q      <= s1_a_d;
         s1_b_q      <= s1_b_d;
         s1_id_q     <= s1_id_d;
         s1_tag_q    <= s1_tag_d;
         res_valid_q <= res_valid_d;
         res_z_q     <= res_z_d;
         res_id_q    <= res_id_d;
         res_tag_q   <= res_tag_d;
         ptr_q       <= ptr_d;
         op_cnt_q    <= op_cnt_d;
      end
   end

   assign res_valid = res_valid_q;
   assign res_z     = res_z_q;
   assign res_id    = res_id_q;
   assign res_tag   = res_tag_q;
   assign busy      = s1_vld_q | res_valid_q;
   assign op_cnt    = op_cnt_q;
endmodule
